rr_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit register among 4 requesters. The register is built from _dff_r cells with a load enable.
- Grants exclusive write ownership to one requester at a time, using a req/grant handshake.
- Drives the shared register's enable and data inputs.
- Enforces a maximum hold time so no requester can starve the others.

---
 rtl/rr_reg_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_reg_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_reg_arbiter
// Description : Round-robin arbiter that gives one of four requesters
//               exclusive write ownership of a shared WIDTH-bit register.
//               A holder keeps ownership for at most MAX_HOLD consecutive
//               cycles while another requester is waiting.
// Ports       : clk            - system clock, rising edge
//               reset          - synchronous active-high reset
//               req[3:0]       - ownership requests
//               wr[3:0]        - write strobes, honoured only for the holder
//               din[4*WIDTH-1:0] - requester data, slice i = [i*WIDTH +: WIDTH]
//               grant[3:0]     - registered one-hot (or zero) ownership
//               reg_en         - shared register load enable (combinational)
//               reg_d          - shared register data (holder's din slice)
//               busy           - some requester holds the register
//               forced_release - one-cycle pulse, the cycle after a timeout
//                                handoff took effect
// Revision    : 1.0 - initial release
// ============================================================================
module rr_reg_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [3:0]           wr,
  input  logic [4*WIDTH-1:0]   din,
  output logic [3:0]           grant,
  output logic                 reg_en,
  output logic [WIDTH-1:0]     reg_d,
  output logic                 busy,
  output logic                 forced_release
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [1:0] last;
  logic [7:0] hold_cnt;
  logic       fr_pend;     // timeout handoff happened at the previous edge

  logic [1:0] holder;
  logic [3:0] others;
  logic [2:0] idle_pick;
  logic [2:0] hand_pick;

  // Round-robin search: first set mask bit starting at base+1 (mod 4),
  // with base itself examined last. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    // Walk from lowest to highest priority so the highest overwrites.
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    holder = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) holder = 2'(i);
    end
  end

  always_comb begin
    others    = req & ~(4'b0001 << holder);
    idle_pick = rr_pick(req, last);
    hand_pick = rr_pick(others, holder);
  end

  // Register write path follows the registered grant directly so a holder
  // can still write in its final granted cycle (and in a reset cycle).
  always_comb begin
    reg_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) reg_d = din[i*WIDTH +: WIDTH];
    end
  end

  assign reg_en = |(grant & wr);
  assign busy   = |grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      grant          <= 4'b0000;
      last           <= 2'd3;
      hold_cnt       <= 8'd0;
      fr_pend        <= 1'b0;
      forced_release <= 1'b0;
    end else begin
      fr_pend        <= 1'b0;
      forced_release <= fr_pend;
      case (state)
        ST_IDLE: begin
          if (idle_pick[2]) begin
            grant    <= 4'b0001 << idle_pick[1:0];
            last     <= idle_pick[1:0];
            hold_cnt <= 8'd0;
            state    <= ST_GRANT;
          end
        end
        default: begin
          if (!req[holder]) begin
            // Voluntary release wins over a coincident timeout.
            hold_cnt <= 8'd0;
            if (hand_pick[2]) begin
              grant <= 4'b0001 << hand_pick[1:0];
              last  <= hand_pick[1:0];
            end else begin
              grant <= 4'b0000;
              state <= ST_IDLE;
            end
          end else if (hold_cnt < HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else if (hand_pick[2]) begin
            grant    <= 4'b0001 << hand_pick[1:0];
            last     <= hand_pick[1:0];
            hold_cnt <= 8'd0;
            fr_pend  <= 1'b1;
          end
          // else: lone holder keeps the grant, counter stays saturated
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_reg_arbiter
// Description : Directed self-checking bench for rr_reg_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_reg_arbiter;

  localparam int WIDTH = 32;

  logic               clk;
  logic               reset;
  logic [3:0]         req;
  logic [3:0]         wr;
  logic [4*WIDTH-1:0] din;
  logic [3:0]         grant;
  logic               reg_en;
  logic [WIDTH-1:0]   reg_d;
  logic               busy;
  logic               forced_release;

  int n_checks;
  int n_fail;

  rr_reg_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .wr             (wr),
    .din            (din),
    .grant          (grant),
    .reg_en         (reg_en),
    .reg_d          (reg_d),
    .busy           (busy),
    .forced_release (forced_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    wr    = 4'b0000;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = 4'b0000;
    wr       = 4'b0000;
    din      = {32'h4444_0003, 32'h3333_0002, 32'hA5A5_0001, 32'h1111_0000};
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_reg_en", 32'(reg_en), 32'h0);
    check("rst_reg_d", reg_d, 32'h0);
    check("rst_fr", 32'(forced_release), 32'h0);

    // Requester 0 first after reset, direct handoff to 2 on release
    req = 4'b0101;
    step();
    check("first_grant", 32'(grant), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    step();
    check("hold0_a", 32'(grant), 32'h1);
    step();
    check("hold0_b", 32'(grant), 32'h1);
    req = 4'b0100;
    step();
    check("handoff_2", 32'(grant), 32'h4);
    check("handoff_busy", 32'(busy), 32'h1);
    check("handoff_fr", 32'(forced_release), 32'h0);
    req = 4'b0000;
    step();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Write path for holder 1
    req = 4'b0010;
    step();
    check("grant_1", 32'(grant), 32'h2);
    wr = 4'b0010;
    #1;
    check("wr_holder_en", 32'(reg_en), 32'h1);
    check("wr_holder_d", reg_d, 32'hA5A5_0001);
    wr = 4'b1000;
    #1;
    check("wr_other_en", 32'(reg_en), 32'h0);
    check("wr_other_d", reg_d, 32'hA5A5_0001);
    wr = 4'b0000;

    // Full contention: each requester held exactly 8 cycles
    do_reset();
    req = 4'b1111;
    step();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        check($sformatf("rot_g r%0d c%0d", r, c), 32'(grant),
              32'(4'b0001 << (r % 4)));
        check($sformatf("rot_fr r%0d c%0d", r, c), 32'(forced_release),
              (r > 0 && c == 1) ? 32'h1 : 32'h0);
        step();
      end
    end

    // Lone holder keeps grant past MAX_HOLD; late arrival wins next edge
    do_reset();
    req = 4'b0001;
    step();
    for (int c = 0; c < 20; c++) begin
      check($sformatf("lone_g c%0d", c), 32'(grant), 32'h1);
      check($sformatf("lone_fr c%0d", c), 32'(forced_release), 32'h0);
      step();
    end
    req = 4'b0101;
    step();
    check("late_g", 32'(grant), 32'h4);
    check("late_fr0", 32'(forced_release), 32'h0);
    step();
    check("late_fr1", 32'(forced_release), 32'h1);
    check("late_g1", 32'(grant), 32'h4);
    step();
    check("late_fr2", 32'(forced_release), 32'h0);

    // Reset mid-grant; write still visible in the reset cycle
    do_reset();
    req = 4'b0010;
    step();
    check("pre_rst_g", 32'(grant), 32'h2);
    wr    = 4'b0010;
    reset = 1'b1;
    #1;
    check("rst_cycle_en", 32'(reg_en), 32'h1);
    step();
    check("mid_rst_g", 32'(grant), 32'h0);
    check("mid_rst_d", reg_d, 32'h0);
    check("mid_rst_en", 32'(reg_en), 32'h0);
    check("mid_rst_fr", 32'(forced_release), 32'h0);
    reset = 1'b0;
    wr    = 4'b0000;
    req   = 4'b1010;
    step();
    check("post_rst_g", 32'(grant), 32'h2);

    // All requests low after release, write strobes ignored
    req = 4'b0000;
    wr  = 4'b1111;
    step();
    check("all_low_g", 32'(grant), 32'h0);
    check("all_low_en", 32'(reg_en), 32'h0);
    check("all_low_busy", 32'(busy), 32'h0);
    wr = 4'b0000;

    // Release coinciding with timeout counts as a release
    do_reset();
    req = 4'b0011;
    step();
    for (int c = 0; c < 7; c++) step();
    check("rel_to_pre", 32'(grant), 32'h1);
    req = 4'b0010;
    step();
    check("rel_to_g", 32'(grant), 32'h2);
    check("rel_to_fr0", 32'(forced_release), 32'h0);
    step();
    check("rel_to_fr1", 32'(forced_release), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
